// File: rtl/mult_div_ctrl.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Divider datapath present only when MULT_DIV_DIVIDE_EN is defined.
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MULT_DIV_DIVIDE_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIXUP, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] prod;
  logic               neg_a;
  logic               neg_b;
  logic               div_op;

  logic               idle;
  logic               start_mul;
  logic               start_div;
  logic               signed_req;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_fix;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] fix_result;

  assign idle      = (state == IDLE) || (state == DONE);
  assign start_mul = Start && idle && ((Op == OP_MULT) || (Op == OP_MULTU));

`ifdef MULT_DIV_DIVIDE_EN
  assign start_div  = Start && idle && ((Op == OP_DIV) || (Op == OP_DIVU));
  assign signed_req = (Op == OP_MULT) || (Op == OP_DIV);
`else
  assign start_div  = 1'b0;
  assign signed_req = (Op == OP_MULT);
`endif

  // Sign flags are captured at accept; magnitudes are formed here in PREP.
  assign mag_a = neg_a ? -a_reg : a_reg;
  assign mag_b = neg_b ? -b_reg : b_reg;

  // Shift-add: upper half accumulates, multiplier bits retire from the bottom.
  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_reg} : '0);
  assign mul_next = {mul_sum, prod[WIDTH-1:1]};
  assign mul_fix  = (neg_a ^ neg_b) ? -prod : prod;

`ifdef MULT_DIV_DIVIDE_EN
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Restoring step: remainder in upper half, dividend shifts out as quotient shifts in.
  assign rem_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, b_reg};
  assign div_next  = rem_diff[WIDTH] ? {rem_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                     : {rem_diff[WIDTH-1:0],  prod[WIDTH-2:0], 1'b1};
  assign quo_fix   = (neg_a ^ neg_b) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
  assign rem_fix   = neg_a ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];

  assign step_next  = div_op ? div_next : mul_next;
  assign fix_result = div_op ? {rem_fix, quo_fix} : mul_fix;
`else
  assign step_next  = mul_next;
  assign fix_result = mul_fix;
  assign DivByZero  = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state  <= IDLE;
      count  <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      prod   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      div_op <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
      DivByZero <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
      DivByZero <= 1'b0;
`endif
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start_mul || start_div) begin
            a_reg  <= A;
            b_reg  <= B;
            neg_a  <= signed_req && A[WIDTH-1];
            neg_b  <= signed_req && B[WIDTH-1];
            div_op <= start_div;
            Busy   <= 1'b1;
            state  <= PREP;
          end else if (Start && (Op == OP_MTHI)) begin
            HI <= A;
          end else if (Start && (Op == OP_MTLO)) begin
            LO <= A;
          end
        end
        PREP: begin
          a_reg <= mag_a;
          b_reg <= mag_b;
          if (div_op && (b_reg == '0)) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
`ifdef MULT_DIV_DIVIDE_EN
            DivByZero <= 1'b1;
`endif
            state <= DONE;
          end else begin
            count <= CW'(WIDTH - 1);
            prod  <= div_op ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            state <= CALC;
          end
        end
        CALC: begin
          prod  <= step_next;
          count <= count - 1'b1;
          if (count == '0) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          HI    <= fix_result[2*WIDTH-1:WIDTH];
          LO    <= fix_result[WIDTH-1:0];
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
